// File: rtl/branch_redirect_controller.sv
// branch_redirect_controller
//   Front-end redirect sequencer sitting between execute and fetch. Each cycle
//   it checks the execute stage's resolved branch outcome against the
//   prediction that travelled with the instruction. On a mismatch it raises a
//   registered PC redirect toward fetch (valid/ready), keeps the front end
//   flushed until fetch accepts, then keeps flushing for a fixed drain period.
//   It also emits a registered predictor/BTB update pulse and keeps saturating
//   branch / mispredict statistics.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   ex_valid                 execute stage holds a valid instruction
//   ex_pc                    PC of the execute instruction
//   ex_is_branch             instruction is a conditional branch
//   ex_branch_taken          resolved direction
//   ex_irreg_pc              resolved target when taken
//   ex_taken_predicted       fetch predicted taken
//   ex_next_pc_predicted     fetch had a BTB target
//   ex_predicted_next_pc     BTB target used by fetch
//   redirect_ready           fetch accepts the redirect
//   redirect_valid           redirect request
//   redirect_pc              PC fetch must restart from
//   flush_front              kill IF/ID and execute-input pipe regs
//   upd_valid                one-cycle predictor/BTB update pulse
//   upd_pc/upd_taken/upd_target  update payload
//   branch_count             qualified branches seen (saturating)
//   mispredict_count         redirects issued (saturating)
module branch_redirect_controller #(
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_is_branch,
  input  logic                 ex_branch_taken,
  input  logic [PC_WIDTH-1:0]  ex_irreg_pc,
  input  logic                 ex_taken_predicted,
  input  logic                 ex_next_pc_predicted,
  input  logic [PC_WIDTH-1:0]  ex_predicted_next_pc,
  input  logic                 redirect_ready,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush_front,
  output logic                 upd_valid,
  output logic [PC_WIDTH-1:0]  upd_pc,
  output logic                 upd_taken,
  output logic [PC_WIDTH-1:0]  upd_target,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Stage p0: resolution compare on the execute-stage inputs
  logic                qual_p0;
  logic                br_p0;
  logic                false_hit_p0;
  logic                mispredict_p0;
  logic                upd_vld_p0;
  logic [PC_WIDTH-1:0] seq_pc_p0;
  logic [PC_WIDTH-1:0] correct_pc_p0;

  // Anything arriving while not IDLE is wrong-path and must be ignored.
  assign qual_p0      = ex_valid && (state == IDLE);
  assign br_p0        = qual_p0 && ex_is_branch;
  assign false_hit_p0 = qual_p0 && !ex_is_branch && ex_taken_predicted;
  assign seq_pc_p0    = ex_pc + PC_WIDTH'(4);

  always_comb begin
    mispredict_p0 = 1'b0;
    if (br_p0) begin
      if (ex_branch_taken != ex_taken_predicted)
        mispredict_p0 = 1'b1;
      else if (ex_branch_taken &&
               (!ex_next_pc_predicted || (ex_predicted_next_pc != ex_irreg_pc)))
        mispredict_p0 = 1'b1;
    end else if (false_hit_p0) begin
      mispredict_p0 = 1'b1;
    end
  end

  assign correct_pc_p0 = (ex_is_branch && ex_branch_taken) ? ex_irreg_pc : seq_pc_p0;
  // A false hit also updates, so the stale BTB entry gets invalidated.
  assign upd_vld_p0    = br_p0 || false_hit_p0;

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (mispredict_p0) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES == 1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt <= 4'd1) state_nxt = IDLE;
        else                   drain_cnt_nxt = drain_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Stage p1: registered redirect target, update payload and statistics
  logic [PC_WIDTH-1:0]  redirect_pc_p1;
  logic                 upd_vld_p1;
  logic [PC_WIDTH-1:0]  upd_pc_p1;
  logic                 upd_taken_p1;
  logic [PC_WIDTH-1:0]  upd_target_p1;
  logic [CNT_WIDTH-1:0] branch_cnt_p1;
  logic [CNT_WIDTH-1:0] mispred_cnt_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_pc_p1 <= '0;
      upd_vld_p1     <= 1'b0;
      upd_pc_p1      <= '0;
      upd_taken_p1   <= 1'b0;
      upd_target_p1  <= '0;
      branch_cnt_p1  <= '0;
      mispred_cnt_p1 <= '0;
    end else begin
      upd_vld_p1 <= upd_vld_p0;
      if (mispredict_p0) begin
        redirect_pc_p1 <= correct_pc_p0;
        mispred_cnt_p1 <= sat_inc(mispred_cnt_p1);
      end
      if (upd_vld_p0) begin
        upd_pc_p1     <= ex_pc;
        upd_taken_p1  <= ex_is_branch && ex_branch_taken;
        upd_target_p1 <= ex_is_branch ? ex_irreg_pc : seq_pc_p0;
      end
      if (br_p0) branch_cnt_p1 <= sat_inc(branch_cnt_p1);
    end
  end

  assign redirect_valid   = (state == REDIRECT);
  assign flush_front      = (state != IDLE);
  assign redirect_pc      = redirect_pc_p1;
  assign upd_valid        = upd_vld_p1;
  assign upd_pc           = upd_pc_p1;
  assign upd_taken        = upd_taken_p1;
  assign upd_target       = upd_target_p1;
  assign branch_count     = branch_cnt_p1;
  assign mispredict_count = mispred_cnt_p1;

endmodule
